// File: rtl/issue_pkg.sv
// Shared types for the issue scheduler: functional-unit class encoding.
package issue_pkg;

  localparam int FU_CLASS_W = 2;

  // Class of work a candidate needs / a port serves.
  typedef enum logic [FU_CLASS_W-1:0] {
    FU_ALU    = 2'd0,
    FU_MEM    = 2'd1,
    FU_BR     = 2'd2,
    FU_MULDIV = 2'd3
  } fu_class_e;

endpackage : issue_pkg

// File: rtl/oldest_picker.sv
// Combinational oldest-first selector: given a request mask and a ROB-relative
// age per requester, returns a one-hot vector naming the oldest requester.
// Equal ages resolve to the lowest index. An empty mask yields all zeros.
module oldest_picker #(
  parameter int NUM_REQ = 4,
  parameter int AGE_W   = 7
) (
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0][AGE_W-1:0] age_i,
  output logic [NUM_REQ-1:0]            grant_o
);

  // A requester wins unless some other active requester is strictly older,
  // or equally old with a lower index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = req_i[i];
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((j != i) && req_i[j] &&
            ((age_i[j] < age_i[i]) || ((age_i[j] == age_i[i]) && (j < i)))) begin
          grant_o[i] = 1'b0;
        end
      end
    end
  end

endmodule : oldest_picker

// File: rtl/issue_scheduler.sv
// Out-of-order issue scheduler. Each cycle, free functional-unit ports are
// filled in ascending port order with the oldest ready candidate of the
// matching class. Issued ops are registered per port; ops that occupy a port
// for several cycles are tracked with a per-port busy countdown.
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int NUM_CAND  = 4,
  parameter int NUM_FU    = 4,
  parameter int ROB_IDX_W = 7,
  parameter int OCC_W     = 5,
  parameter int PAYLOAD_W = 128,
  parameter logic [NUM_FU*FU_CLASS_W-1:0] FU_CLASS_MAP = {FU_BR, FU_MEM, FU_ALU, FU_ALU}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ROB_IDX_W-1:0]           rob_head,
  input  logic [NUM_CAND-1:0]            cand_valid,
  input  logic [NUM_CAND*FU_CLASS_W-1:0] cand_class,
  input  logic [NUM_CAND*ROB_IDX_W-1:0]  cand_rob_idx,
  input  logic [NUM_CAND*OCC_W-1:0]      cand_occ,
  input  logic [NUM_CAND*PAYLOAD_W-1:0]  cand_payload,
  output logic [NUM_CAND-1:0]            cand_ack,
  input  logic [NUM_FU-1:0]              fu_stall,
  output logic [NUM_FU-1:0]              iss_valid,
  output logic [NUM_FU*ROB_IDX_W-1:0]    iss_rob_idx,
  output logic [NUM_FU*PAYLOAD_W-1:0]    iss_payload,
  output logic [NUM_FU-1:0]              fu_busy
);

  // Age relative to the ROB head; modular subtraction keeps ordering correct
  // across ROB index wrap-around.
  logic [NUM_CAND-1:0][ROB_IDX_W-1:0] cand_age;

  // Candidates eligible for any port this cycle. Nothing is offered during a
  // flush or while reset is held, which forces cand_ack low.
  logic [NUM_CAND-1:0] avail_base;

  // Compute each candidate's age from the ROB head.
  always_comb begin
    for (int c = 0; c < NUM_CAND; c++) begin
      cand_age[c] = cand_rob_idx[c*ROB_IDX_W +: ROB_IDX_W] - rob_head;
    end
  end

  assign avail_base = (flush || rst) ? '0 : cand_valid;

  // One slice per port. The availability mask and the accumulated ack are
  // passed from port p-1 to port p, so a candidate taken by a lower port is
  // never offered to a higher one.
  for (genvar p = 0; p < NUM_FU; p++) begin : g_port
    logic [NUM_CAND-1:0]  avail_in;
    logic [NUM_CAND-1:0]  avail_out;
    logic [NUM_CAND-1:0]  ack_in;
    logic [NUM_CAND-1:0]  ack_out;
    logic [NUM_CAND-1:0]  class_hit;
    logic [NUM_CAND-1:0]  req;
    logic [NUM_CAND-1:0]  grant;
    logic                 port_free;
    logic [ROB_IDX_W-1:0] sel_rob;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [OCC_W-1:0]     sel_occ;

    logic                 valid_q,   valid_d;
    logic [ROB_IDX_W-1:0] rob_q,     rob_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [OCC_W-1:0]     busy_q,    busy_d;

    if (p == 0) begin : g_head
      assign avail_in = avail_base;
      assign ack_in   = '0;
    end else begin : g_chain
      assign avail_in = g_port[p-1].avail_out;
      assign ack_in   = g_port[p-1].ack_out;
    end

    for (genvar c = 0; c < NUM_CAND; c++) begin : g_class
      assign class_hit[c] = (cand_class[c*FU_CLASS_W +: FU_CLASS_W] ==
                             FU_CLASS_MAP[p*FU_CLASS_W +: FU_CLASS_W]);
    end

    // A port can accept a new op once its occupancy has drained and its
    // current issue slot is empty or being consumed this cycle.
    assign port_free = (busy_q == '0) && (!valid_q || !fu_stall[p]);
    assign req       = avail_in & class_hit & {NUM_CAND{port_free}};

    oldest_picker #(
      .NUM_REQ (NUM_CAND),
      .AGE_W   (ROB_IDX_W)
    ) u_picker (
      .req_i   (req),
      .age_i   (cand_age),
      .grant_o (grant)
    );

    assign avail_out = avail_in & ~grant;
    assign ack_out   = ack_in | grant;

    // Steer the granted candidate's fields onto this port (one-hot AND-OR mux).
    always_comb begin
      sel_rob     = '0;
      sel_payload = '0;
      sel_occ     = '0;
      for (int c = 0; c < NUM_CAND; c++) begin
        if (grant[c]) begin
          sel_rob     = sel_rob     | cand_rob_idx[c*ROB_IDX_W +: ROB_IDX_W];
          sel_payload = sel_payload | cand_payload[c*PAYLOAD_W +: PAYLOAD_W];
          sel_occ     = sel_occ     | cand_occ[c*OCC_W +: OCC_W];
        end
      end
    end

    // Next-state for the issue register and occupancy counter. A grant only
    // happens when the counter is zero, so load and decrement never collide.
    // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latch).
    always_comb begin
      valid_d   = valid_q;
      rob_d     = rob_q;
      payload_d = payload_q;
      busy_d    = busy_q;
      if (|grant) begin
        valid_d   = 1'b1;
        rob_d     = sel_rob;
        payload_d = sel_payload;
        busy_d    = sel_occ;
      end else begin
        if (busy_q != '0) begin
          busy_d = busy_q - {{(OCC_W-1){1'b0}}, 1'b1};
        end
        // A flush squashes the held issue even if the unit is stalled; the
        // busy count keeps draining since the unit is still occupied.
        if (flush || !fu_stall[p]) begin
          valid_d = 1'b0;
        end
      end
    end

    // Per-port state registers with asynchronous reset.
    // NOTE: index and payload flops are reset as well so the issue outputs read
    // all-zero during reset rather than stale data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q   <= 1'b0;
        rob_q     <= '0;
        payload_q <= '0;
        busy_q    <= '0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        valid_q   <= valid_d;
        rob_q     <= rob_d;
        payload_q <= payload_d;
        busy_q    <= busy_d;
      end
    end

    assign iss_valid[p]                             = valid_q;
    assign iss_rob_idx[p*ROB_IDX_W +: ROB_IDX_W]    = rob_q;
    assign iss_payload[p*PAYLOAD_W +: PAYLOAD_W]    = payload_q;
    assign fu_busy[p]                               = (busy_q != '0);
  end : g_port

  assign cand_ack = g_port[NUM_FU-1].ack_out;

endmodule : issue_scheduler
